// File: rtl/rrq_pkg.sv
// Shared types and width helpers for the round-robin quantum arbiter.
// The optional owner lock port is enabled by defining RRQ_LOCK_EN.
package rrq_pkg;

   typedef enum logic [1:0] {
      RRQ_IDLE,
      RRQ_GRANT,
      RRQ_HANDOFF
   } rrq_state_t;

   localparam int RRQ_N_DEFAULT       = 4;
   localparam int RRQ_QUANTUM_DEFAULT = 8;

   function automatic int rrq_width(input int value);
      return (value > 2) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/rrq_rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping to 0.
module rrq_rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic            valid,
   output logic [ID_W-1:0] idx
);

   logic [ID_W-1:0] cand;

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = ID_W'((int'(ptr) + k) % N);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rr_quantum_arbiter.sv
// N-way round-robin arbiter with a grant quantum and a dead handoff cycle.
// Define RRQ_LOCK_EN to add a lock input that suppresses quantum preemption.
module rr_quantum_arbiter
   import rrq_pkg::*;
#(
   parameter int N       = RRQ_N_DEFAULT,
   parameter int QUANTUM = RRQ_QUANTUM_DEFAULT,
   parameter int ID_W    = rrq_width(N),
   parameter int CNT_W   = rrq_width(QUANTUM)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
`ifdef RRQ_LOCK_EN
   input  logic            lock,
`endif
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            busy,
   output logic            expired
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM - 1);

   rrq_state_t      state_q, state_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [ID_W-1:0] gnt_id_q, gnt_id_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            expired_q, expired_d;

   logic            pick_valid;
   logic [ID_W-1:0] pick_idx;
   logic [ID_W-1:0] pick_next;
   logic            others_waiting;
   logic            lock_hold;

`ifdef RRQ_LOCK_EN
   assign lock_hold = lock;
`else
   assign lock_hold = 1'b0;
`endif

   rrq_rr_pick #(
      .N    (N),
      .ID_W (ID_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign pick_next      = (pick_idx == ID_W'(N - 1)) ? '0 : pick_idx + 1'b1;
   assign others_waiting = |(req & ~gnt_q);

   // IDLE and HANDOFF both grant to the pick; HANDOFF never lingers a second cycle.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      expired_d = 1'b0;
      case (state_q)
         RRQ_IDLE, RRQ_HANDOFF: begin
            gnt_d    = '0;
            gnt_id_d = '0;
            cnt_d    = '0;
            state_d  = RRQ_IDLE;
            if (pick_valid) begin
               state_d         = RRQ_GRANT;
               gnt_d[pick_idx] = 1'b1;
               gnt_id_d        = pick_idx;
               ptr_d           = pick_next;
            end
         end
         RRQ_GRANT: begin
            if (!req[gnt_id_q]) begin
               state_d  = RRQ_HANDOFF;
               gnt_d    = '0;
               gnt_id_d = '0;
               cnt_d    = '0;
            end else if (cnt_q == CNT_MAX) begin
               if (lock_hold) begin
                  cnt_d = CNT_MAX;
               end else if (others_waiting) begin
                  state_d   = RRQ_HANDOFF;
                  gnt_d     = '0;
                  gnt_id_d  = '0;
                  cnt_d     = '0;
                  expired_d = 1'b1;
               end else begin
                  cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d  = RRQ_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            cnt_d    = '0;
         end
      endcase
      busy_d = (state_d == RRQ_GRANT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RRQ_IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         expired_q <= expired_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign busy    = busy_q;
   assign expired = expired_q;

endmodule
